// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg: shared types and constants for the execution sequencer.
//   - state_e      : sequencer state encoding (also exported on curr_state)
//   - *_DEF        : default field widths, memory depth and watchdog limit
//   - BRICK        : all-zero instruction word that halts the sequencer
//   - JUMP_OP      : all-ones opcode, an unconditional jump when the
//                    EXE_SEQ_JUMP_EN build option is enabled
//   - field_slice  : extracts one field from a packed instruction word
// ---------------------------------------------------------------------------
package exe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_HALT      = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int OP_W_DEF    = 3;
    localparam int REG_W_DEF   = 4;
    localparam int IMM_W_DEF   = 8;
    localparam int DEPTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;
    localparam int INSTR_W_DEF = OP_W_DEF + 2 * REG_W_DEF + IMM_W_DEF;

    // Widest instruction word the slicing helper handles.
    localparam int SLICE_W = 64;

    localparam logic [INSTR_W_DEF-1:0] BRICK   = {INSTR_W_DEF{1'b0}};
    localparam logic [OP_W_DEF-1:0]    JUMP_OP = {OP_W_DEF{1'b1}};

    // Returns word[lsb +: width], zero-extended; width must be 1..SLICE_W.
    function automatic logic [SLICE_W-1:0] field_slice(
        input logic [SLICE_W-1:0] word,
        input int                 lsb,
        input int                 width
    );
        logic [SLICE_W-1:0] mask;
        mask = {SLICE_W{1'b1}} >> (SLICE_W - width);
        return (word >> lsb) & mask;
    endfunction

endpackage

// File: rtl/exe_prog_mem.sv
// ---------------------------------------------------------------------------
// exe_prog_mem: DEPTH x INSTR_W program store, no reset (contents survive rst).
//   clk      in   write clock
//   we       in   write strobe (already qualified by the sequencer state)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   asynchronous read address
//   rd_data  out  word at rd_addr; all-zero (a brick) for addresses >= DEPTH
// ---------------------------------------------------------------------------
module exe_prog_mem #(
    parameter int DEPTH   = 16,
    parameter int PC_W    = 4,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [PC_W-1:0]    rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    localparam logic [PC_W:0] DEPTH_V = (PC_W + 1)'(DEPTH);

    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic               wr_ok_s;
    logic               rd_ok_s;

    assign wr_ok_s = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_ok_s = ({1'b0, rd_addr} < DEPTH_V);

    // Write port: one word per clock when enabled and in range.
    always_ff @(posedge clk) begin
        if (we && wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: out-of-range addresses (non power-of-two DEPTH) read as a brick.
    always_comb begin
        rd_data = {INSTR_W{1'b0}};
        if (rd_ok_s) begin
            rd_data = mem_r[rd_addr];
        end else begin
            rd_data = {INSTR_W{1'b0}};
        end
    end

endmodule

// File: rtl/exe_seq.sv
// ---------------------------------------------------------------------------
// exe_seq: execution sequencer. Fetches words from a loadable program memory,
// decodes {op,s1,s2,dest} (MSB->LSB), issues a one-cycle en_alu pulse and
// waits for alu_done, with brick / end-of-memory halt and a watchdog fault.
//
// Build option: define EXE_SEQ_JUMP_EN to make the all-ones opcode an
// unconditional jump to s2[PC_W-1:0] (no ALU dispatch, no watchdog).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   prog_we/addr/data   program load port, honoured only in IDLE/HALT/FAULT
//   start               begin execution at pc 0 (from IDLE, HALT or FAULT)
//   alu_done            ALU completion, only looked at in WAIT_DONE
//   op, s1, s2, dest    registered instruction fields
//   en_alu              one-cycle ALU start pulse
//   stop, err           halted / watchdog fault (sticky until start)
//   busy                in DECODE or WAIT_DONE
//   pc, curr_state      program counter and state, for debug
// ---------------------------------------------------------------------------
module exe_seq
    import exe_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int PC_W    = $clog2(DEPTH),
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int INSTR_W = OP_W + 2 * REG_W + IMM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               alu_done,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   s1,
    output logic [IMM_W-1:0]   s2,
    output logic [REG_W-1:0]   dest,
    output logic               en_alu,
    output logic               stop,
    output logic               err,
    output logic               busy,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         curr_state
);

    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int OP_LSB  = 2 * REG_W + IMM_W;
    localparam int S1_LSB  = REG_W + IMM_W;
    localparam int S2_LSB  = REG_W;
    localparam int DST_LSB = 0;

    // The counter is cleared on entry to WAIT_DONE, so the edge that sees it
    // at TIMEOUT-1 is the TIMEOUT-th edge spent in WAIT_DONE.
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [PC_W-1:0]    PC_LAST    = PC_W'(DEPTH - 1);
    localparam logic [INSTR_W-1:0] WORD_BRICK = INSTR_W'(BRICK);
`ifdef EXE_SEQ_JUMP_EN
    localparam logic [OP_W-1:0]    OP_JUMP    = {OP_W{JUMP_OP[0]}};
`endif

    state_e             state_r, state_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [OP_W-1:0]    op_r, op_s;
    logic [REG_W-1:0]   s1_r, s1_s;
    logic [IMM_W-1:0]   s2_r, s2_s;
    logic [REG_W-1:0]   dest_r, dest_s;
    logic               en_alu_r, en_alu_s;
    logic               stop_r, stop_s;
    logic               err_r, err_s;
    logic               busy_r, busy_s;

    logic [INSTR_W-1:0] word_s;
    logic               mem_we_s;
    logic [OP_W-1:0]    dec_op_s;
    logic [REG_W-1:0]   dec_s1_s;
    logic [IMM_W-1:0]   dec_s2_s;
    logic [REG_W-1:0]   dec_dest_s;

    // Loads are only accepted while no instruction is in flight.
    assign mem_we_s = prog_we &&
                      ((state_r == ST_IDLE) || (state_r == ST_HALT) || (state_r == ST_FAULT));

    exe_prog_mem #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we_s),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (pc_r),
        .rd_data (word_s)
    );

    // Split the fetched word into its fields.
    always_comb begin
        dec_op_s   = OP_W'(field_slice(SLICE_W'(word_s), OP_LSB, OP_W));
        dec_s1_s   = REG_W'(field_slice(SLICE_W'(word_s), S1_LSB, REG_W));
        dec_s2_s   = IMM_W'(field_slice(SLICE_W'(word_s), S2_LSB, IMM_W));
        dec_dest_s = REG_W'(field_slice(SLICE_W'(word_s), DST_LSB, REG_W));
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        cnt_s    = cnt_r;
        op_s     = op_r;
        s1_s     = s1_r;
        s2_s     = s2_r;
        dest_s   = dest_r;
        en_alu_s = 1'b0;
        stop_s   = stop_r;
        err_s    = err_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_DECODE;
                    pc_s    = {PC_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_DECODE: begin
                if (word_s == WORD_BRICK) begin
                    state_s = ST_HALT;
                    stop_s  = 1'b1;
                    op_s    = {OP_W{1'b0}};
                    s1_s    = {REG_W{1'b0}};
                    s2_s    = {IMM_W{1'b0}};
                    dest_s  = {REG_W{1'b0}};
                end
`ifdef EXE_SEQ_JUMP_EN
                else if (dec_op_s == OP_JUMP) begin
                    state_s = ST_DECODE;
                    pc_s    = PC_W'(dec_s2_s);
                end
`endif
                else begin
                    state_s  = ST_WAIT_DONE;
                    op_s     = dec_op_s;
                    s1_s     = dec_s1_s;
                    s2_s     = dec_s2_s;
                    dest_s   = dec_dest_s;
                    en_alu_s = 1'b1;
                    cnt_s    = {CNT_W{1'b0}};
                end
            end

            ST_WAIT_DONE: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (alu_done) begin
                    if (pc_r == PC_LAST) begin
                        state_s = ST_HALT;
                        stop_s  = 1'b1;
                        op_s    = {OP_W{1'b0}};
                        s1_s    = {REG_W{1'b0}};
                        s2_s    = {IMM_W{1'b0}};
                        dest_s  = {REG_W{1'b0}};
                    end else begin
                        state_s = ST_DECODE;
                        pc_s    = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_FAULT;
                    err_s   = 1'b1;
                    op_s    = {OP_W{1'b0}};
                    s1_s    = {REG_W{1'b0}};
                    s2_s    = {IMM_W{1'b0}};
                    dest_s  = {REG_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_HALT, ST_FAULT: begin
                if (start) begin
                    state_s = ST_DECODE;
                    pc_s    = {PC_W{1'b0}};
                    stop_s  = 1'b0;
                    err_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
                pc_s    = {PC_W{1'b0}};
                op_s    = {OP_W{1'b0}};
                s1_s    = {REG_W{1'b0}};
                s2_s    = {IMM_W{1'b0}};
                dest_s  = {REG_W{1'b0}};
                stop_s  = 1'b0;
                err_s   = 1'b0;
            end
        endcase

        busy_s = (state_s == ST_DECODE) || (state_s == ST_WAIT_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= {PC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= {OP_W{1'b0}};
            s1_r     <= {REG_W{1'b0}};
            s2_r     <= {IMM_W{1'b0}};
            dest_r   <= {REG_W{1'b0}};
            en_alu_r <= 1'b0;
            stop_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            cnt_r    <= cnt_s;
            op_r     <= op_s;
            s1_r     <= s1_s;
            s2_r     <= s2_s;
            dest_r   <= dest_s;
            en_alu_r <= en_alu_s;
            stop_r   <= stop_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
        end
    end

    assign op         = op_r;
    assign s1         = s1_r;
    assign s2         = s2_r;
    assign dest       = dest_r;
    assign en_alu     = en_alu_r;
    assign stop       = stop_r;
    assign err        = err_r;
    assign busy       = busy_r;
    assign pc         = pc_r;
    assign curr_state = state_r;

endmodule

// File: tb/tb_exe_seq.sv
// ---------------------------------------------------------------------------
// tb_exe_seq: self-checking bench for exe_seq (default widths, DEPTH 16,
// TIMEOUT 255). Directed decode table, hand-written multi-cycle sequences,
// and random programs compared against a program-level reference model.
// ---------------------------------------------------------------------------
module tb_exe_seq;
    import exe_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;
    localparam int BUDGET  = 400;

    logic        clk = 1'b0;
    logic        rst, prog_we, start, alu_done;
    logic [3:0]  prog_addr;
    logic [18:0] prog_data;
    logic [2:0]  op;
    logic [3:0]  s1, dest, pc;
    logic [7:0]  s2;
    logic        en_alu, stop, err, busy;
    logic [2:0]  curr_state;

    exe_seq #(
        .OP_W(3), .REG_W(4), .IMM_W(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .alu_done(alu_done),
        .op(op), .s1(s1), .s2(s2), .dest(dest), .en_alu(en_alu),
        .stop(stop), .err(err), .busy(busy), .pc(pc), .curr_state(curr_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] s1;
        logic [7:0] s2;
        logic [3:0] dest;
        logic [3:0] pc;
    } rec_t;

    typedef struct {
        logic [18:0] w;
        logic        en;
        logic [2:0]  op;
        logic [3:0]  s1;
        logic [7:0]  s2;
        logic [3:0]  dest;
    } vec_t;

    logic [18:0] mem_m [DEPTH];
    rec_t        cap_q [$];
    rec_t        exp_q [$];
    vec_t        vt    [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [18:0] d);
        prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
        step();
        prog_we = 1'b0;
        mem_m[a] = d;
    endtask

    // Program-level reference: walk the program, list the ALU dispatches,
    // count edges from DECODE entry until stop (d = ALU done delay).
    task automatic model_run(input int d, output int n_cyc, output logic [3:0] end_pc);
        int          p;
        rec_t        r;
        logic [18:0] w;
        exp_q.delete();
        n_cyc = 0;
        p = 0;
        for (int k = 0; k < 64; k++) begin
            w = mem_m[p];
            if (w == 19'd0) begin
                n_cyc += 1;
                break;
            end
            {r.op, r.s1, r.s2, r.dest} = w;
`ifdef EXE_SEQ_JUMP_EN
            if (r.op == JUMP_OP) begin
                n_cyc += 1;
                p = int'(r.s2[3:0]);
                continue;
            end
`endif
            r.pc = 4'(p);
            exp_q.push_back(r);
            n_cyc += d + 2;
            if (p == DEPTH - 1) break;
            p++;
        end
        end_pc = 4'(p);
    endtask

    // Pulse start, act as an ALU answering d cycles after en_alu, record each
    // dispatch. noise: spurious start while busy, spurious done in DECODE.
    task automatic run_prog(input int d, input bit noise, input int wr_at,
                            input logic [3:0] wa, input logic [18:0] wd, output int cyc);
        bit pend;
        int cd;
        pend = 1'b0; cd = 0; cyc = 0;
        cap_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        while (!(stop || err) && cyc < BUDGET) begin
            if (en_alu) begin
                cap_q.push_back({op, s1, s2, dest, pc});
                pend = 1'b1;
                cd = d;
            end
            alu_done = 1'b0;
            if (pend && cd == 0) begin
                alu_done = 1'b1;
                pend = 1'b0;
            end else if (pend) begin
                cd--;
            end
            if (noise && curr_state == 3'd1 && $urandom_range(1) == 1) alu_done = 1'b1;
            start     = noise && busy && ($urandom_range(1) == 1);
            prog_we   = (cyc == wr_at);
            prog_addr = wa;
            prog_data = wd;
            step();
            cyc++;
        end
        alu_done = 1'b0; start = 1'b0; prog_we = 1'b0;
    endtask

    task automatic run_and_check(input string nm, input int d, input bit noise, input int wr_at,
                                 input logic [3:0] wa, input logic [18:0] wd);
        int         cyc, ecyc;
        logic [3:0] epc;
        model_run(d, ecyc, epc);
        run_prog(d, noise, wr_at, wa, wd, cyc);
        chk({nm, "_in_budget"}, 32'(cyc < BUDGET), 32'd1);
        chk({nm, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk({nm, "_dispatch"}, 32'(cap_q[i]), 32'(exp_q[i]));
        chk({nm, "_cycles"}, cyc, ecyc);
        chk({nm, "_stop"}, stop, 1'b1);
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_pc"}, pc, epc);
        chk({nm, "_state"}, curr_state, 3'd3);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_fields"}, {op, s1, s2, dest}, 19'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [18:0] w;
        rst = 1'b1; prog_we = 1'b0; start = 1'b0; alu_done = 1'b0;
        prog_addr = 4'd0; prog_data = 19'd0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 19'd0;

        // ---- reset state ----
        step(); step();
        rst = 1'b0;
        chk("rst_state", curr_state, 3'd0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_outs", {en_alu, stop, err, busy}, 4'd0);
        chk("rst_fields", {op, s1, s2, dest}, 19'd0);
        step();
        chk("idle_hold", curr_state, 3'd0);

        // ---- decode table: word at addr 0, brick at addr 1 ----
        vt.push_back('{19'h10012, 1'b1, 3'd1, 4'd0, 8'h01, 4'd2});
        vt.push_back('{19'h25A59, 1'b1, 3'd2, 4'd5, 8'hA5, 4'd9});
        vt.push_back('{19'h00001, 1'b1, 3'd0, 4'd0, 8'h00, 4'd1});
        vt.push_back('{19'h00800, 1'b1, 3'd0, 4'd0, 8'h80, 4'd0});
        vt.push_back('{19'h6C3C0, 1'b1, 3'd6, 4'hC, 8'h3C, 4'd0});
        vt.push_back('{19'h00000, 1'b0, 3'd0, 4'd0, 8'h00, 4'd0});
`ifndef EXE_SEQ_JUMP_EN
        vt.push_back('{19'h7FFFF, 1'b1, 3'd7, 4'hF, 8'hFF, 4'hF});
`endif
        load(1, 19'd0);
        for (int i = 0; i < vt.size(); i++) begin
            load(0, vt[i].w);
            start = 1'b1;
            step();
            start = 1'b0;
            chk("tbl_decode_state", curr_state, 3'd1);
            step();
            chk("tbl_en", en_alu, vt[i].en);
            chk("tbl_fields", {op, s1, s2, dest}, {vt[i].op, vt[i].s1, vt[i].s2, vt[i].dest});
            if (vt[i].en) begin
                alu_done = 1'b1;
                step();
                alu_done = 1'b0;
                chk("tbl_pc_inc", pc, 4'd1);
                step();
            end
            chk("tbl_stop", stop, 1'b1);
            chk("tbl_halt_fields", {op, s1, s2, dest}, 19'd0);
        end

        // ---- 5-instruction program + brick, done 1 cycle after en_alu ----
        load(0, {3'd1, 4'd0, 8'h01, 4'd2});
        load(1, {3'd2, 4'd1, 8'h02, 4'd3});
        load(2, {3'd3, 4'd2, 8'h03, 4'd4});
        load(3, {3'd4, 4'd3, 8'h04, 4'd5});
        load(4, {3'd5, 4'd4, 8'h05, 4'd6});
        load(5, 19'd0);
        run_and_check("prog5", 1, 1'b0, -1, 4'd0, 19'd0);
        chk("prog5_pulses", cap_q.size(), 5);
        if (cap_q.size() > 0) chk("prog5_first", 32'(cap_q[0]), {3'd1, 4'd0, 8'h01, 4'd2, 4'd0});
        chk("prog5_end_pc", pc, 4'd5);

        // ---- full memory, no wrap ----
        for (int i = 0; i < DEPTH; i++) begin
            w = {3'd2, 4'(i), 8'(i * 3 + 1), 4'(15 - i)};
            load(i, w);
        end
        run_and_check("full", 0, 1'b0, -1, 4'd0, 19'd0);
        chk("full_pulses", cap_q.size(), 16);
        chk("full_end_pc", pc, 4'd15);

        // ---- write while busy ignored, write in HALT applied ----
        load(0, {3'd1, 4'd1, 8'h10, 4'd1});
        load(1, {3'd1, 4'd2, 8'h20, 4'd2});
        load(2, {3'd1, 4'd3, 8'h30, 4'd3});
        load(3, {3'd1, 4'd4, 8'h40, 4'd4});
        load(4, 19'd0);
        run_and_check("busy_wr", 0, 1'b0, 2, 4'd3, 19'd0);
        load(3, {3'd6, 4'd6, 8'h66, 4'd6});
        run_and_check("halt_wr", 0, 1'b0, -1, 4'd0, 19'd0);
        if (cap_q.size() > 3) chk("halt_wr_new_s2", cap_q[3].s2, 8'h66);

        // ---- watchdog: fault exactly TIMEOUT cycles into WAIT_DONE ----
        load(0, {3'd3, 4'd1, 8'h10, 4'd7});
        load(1, 19'd0);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("wd_enter", curr_state, 3'd2);
        repeat (TIMEOUT - 1) step();
        chk("wd_not_yet_state", curr_state, 3'd2);
        chk("wd_not_yet_err", err, 1'b0);
        step();
        chk("wd_fault_state", curr_state, 3'd4);
        chk("wd_err", err, 1'b1);
        chk("wd_fault_outs", {stop, busy, en_alu}, 3'd0);
        chk("wd_fault_fields", {op, s1, s2, dest}, 19'd0);
        step();
        chk("wd_sticky", {curr_state, err}, {3'd4, 1'b1});
        start = 1'b1; step(); start = 1'b0;
        chk("wd_restart", {curr_state, err, pc}, {3'd1, 1'b0, 4'd0});
        // done arriving on the timeout edge wins
        step();
        repeat (TIMEOUT - 1) step();
        alu_done = 1'b1; step(); alu_done = 1'b0;
        chk("wd_done_wins", {curr_state, err, pc}, {3'd1, 1'b0, 4'd1});
        step();
        chk("wd_then_halt", {curr_state, stop}, {3'd3, 1'b1});

        // ---- reset in WAIT_DONE ----
        load(0, {3'd1, 4'd0, 8'h01, 4'd2});
        load(1, {3'd2, 4'd1, 8'h02, 4'd3});
        load(2, 19'd0);
        start = 1'b1; step(); start = 1'b0;
        step();
        alu_done = 1'b1; step(); alu_done = 1'b0;
        step();
        chk("mid_en", {curr_state, en_alu, pc}, {3'd2, 1'b1, 4'd1});
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_state", curr_state, 3'd0);
        chk("mid_rst_pc", pc, 4'd0);
        chk("mid_rst_outs", {en_alu, stop, err, busy}, 4'd0);
        chk("mid_rst_fields", {op, s1, s2, dest}, 19'd0);
        step();
        chk("mid_rst_quiet", {curr_state, en_alu}, {3'd0, 1'b0});
        run_and_check("post_rst", 1, 1'b0, -1, 4'd0, 19'd0);

        // ---- all-ones opcode: jump or ordinary dispatch ----
        load(0, {JUMP_OP, 4'd0, 8'h02, 4'd0});
        load(1, {3'd1, 4'd1, 8'h11, 4'd1});
        load(2, {3'd2, 4'd2, 8'h22, 4'd2});
        load(3, 19'd0);
        run_and_check("allones", 1, 1'b0, -1, 4'd0, 19'd0);
`ifdef EXE_SEQ_JUMP_EN
        chk("jump_pulses", cap_q.size(), 1);
        if (cap_q.size() > 0) chk("jump_target", {cap_q[0].pc, cap_q[0].s2}, {4'd2, 8'h22});
`else
        chk("op7_pulses", cap_q.size(), 3);
        if (cap_q.size() > 0) chk("op7_dispatch", {cap_q[0].op, cap_q[0].s2}, {3'd7, 8'h02});
`endif

        // ---- random programs with noisy start/done ----
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = 19'($urandom);
`ifdef EXE_SEQ_JUMP_EN
                if (w[18:16] == JUMP_OP) w[18:16] = 3'd6;
`endif
                if ($urandom_range(5) == 0) w = 19'd0;
                load(i, w);
            end
            run_and_check("rand", int'($urandom_range(3)), 1'b1, -1, 4'd0, 19'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
